dcache_port_arbiter: RTL
========================

Name: dcache_port_arbiter

Overview:
- Shares the single D$ request port between the MMU page-table walker (port M) and the pipeline load/store unit (port C).
- Replaces the combinational use_dcache mux in front of the D$.
- Latches one request at a time, holds it stable on the D$ until the D$ completes, routes the response back to the owner, and inserts a one-cycle enable-low gap between transactions.
- Fixed priority to M, with a starvation guard for C and a sticky watchdog on D$ hangs.

Parameters:
- STARVE_LIMIT, 4: consecutive M grants allowed while C waits before C is forced.
- TIMEOUT, 1024: max BUSY cycles before err_timeout sets.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- virtual_en  in  1  translation enabled for pipeline accesses
- m_req_valid  in  1  walker read request; held until m_resp_valid
- m_req_addr  in  64  physical PTE address
- m_resp_valid  out  1  one-cycle response pulse to walker
- m_resp_data  out  64  PTE data (valid with m_resp_valid, else 0)
- c_req_valid  in  1  pipeline request; held until c_resp_valid
- c_req_addr  in  64  virtual or physical address
- c_req_write  in  1  1 = store, 0 = load
- c_req_wdata  in  64  store data
- c_req_wlen  in  2  log2(bytes)
- c_resp_valid  out  1  one-cycle pulse: load data valid or store done
- c_resp_rdata  out  64  load data (0 for stores and when not valid)
- dc_en  out  1  D$ enable
- dc_addr  out  64  D$ address
- dc_write_en  out  1  D$ write
- dc_wdata  out  64  D$ write data
- dc_wlen  out  2  D$ write length
- dc_virtual_mode  out  1  virtual_en && owner==C; 0 when owner is M
- dc_rdata  in  64  D$ read data
- dc_rvalid  in  1  D$ read complete
- dc_write_done  in  1  D$ write complete
- owner  out  1  0 = M, 1 = C; valid while dc_en=1
- err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; starve_cnt = 0; timer = 0; err_timeout = 0.
  - All dc_* outputs = 0, owner = 0, both resp_valid = 0, both resp data = 0.
- States: IDLE, BUSY, GAP.
- IDLE, arbitration on registered inputs:
  - If C is pending and starve_cnt == STARVE_LIMIT: grant C.
  - Else if M is pending: grant M.
  - Else if C is pending: grant C.
  - On grant: latch addr/write/wdata/wlen into the request register, set owner, go to BUSY. dc_en rises the cycle after the request is seen (one-cycle grant latency).
- M requests always go to the D$ with write_en=0, wdata=0, wlen=0.
- starve_cnt:
  - Increments on each M grant made while c_req_valid=1.
  - Clears on any C grant.
  - Clears on an M grant made while c_req_valid=0.
  - Saturates at STARVE_LIMIT.
- BUSY:
  - dc_en=1; dc_* driven from the request register only, so they stay constant even if requester inputs change.
  - Completion is dc_rvalid (read) or dc_write_done (write), qualified by the latched write bit.
  - On completion, in the same cycle (combinational routing): owner's resp_valid=1 and resp data = dc_rdata (0 for stores). The other port's resp_valid stays 0.
  - Next state is GAP.
- GAP: dc_en=0 for exactly one cycle so the D$ sees a fresh request, then IDLE. Arbitration does not occur in GAP. Minimum back-to-back spacing is request seen → BUSY → complete → GAP → IDLE.
- Requester drops req_valid while BUSY: the transaction still completes and resp_valid still pulses; the requester discards it.
- Simultaneous M and C requests in IDLE: M wins unless the starvation condition holds.
- dc_rvalid or dc_write_done seen in IDLE or GAP: ignored, no resp pulse.
- Watchdog:
  - timer increments each BUSY cycle and clears on leaving BUSY.
  - When timer == TIMEOUT, err_timeout is set and stays set until reset. The state machine stays in BUSY.
- Reset asserted mid-BUSY: dc_en drops asynchronously and the latched request is lost. Requesters must re-issue after reset.
- timer width is clog2(TIMEOUT+1); starve_cnt width is clog2(STARVE_LIMIT+1).

Test Plan:
- C load only, addr 0x8000_0040, D$ returns rvalid with 0xDEAD_BEEF after 3 BUSY cycles:
  - dc_en rises 1 cycle after the request; c_resp_valid pulses once with rdata 0xDEAD_BEEF.
  - dc_en=0 for 1 cycle, then IDLE.
- M and C request in the same cycle:
  - M granted first (owner=0, dc_write_en=0, dc_virtual_mode=0); C granted after GAP with dc_virtual_mode=virtual_en.
  - m_resp_valid and c_resp_valid never both 1.
- M continuously requesting, C pending, STARVE_LIMIT=4:
  - Exactly 4 M grants, then a C grant, then starve_cnt=0 and M resumes.
- C store, wdata 0x1122, wlen 1, c_req_* changed mid-BUSY:
  - dc_wdata stays 0x1122 and dc_wlen stays 1.
  - c_resp_valid pulses on dc_write_done with c_resp_rdata=0.
- D$ never responds, TIMEOUT=16:
  - err_timeout sets after 16 BUSY cycles and stays set.
  - Async reset (reset=0) clears err_timeout and dc_en immediately.
- Spurious dc_rvalid in IDLE: no resp pulse on either port.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single D$ request port between the MMU page-table walker
//   (port M, read-only) and the pipeline load/store unit (port C).
//   One request is latched at a time and held stable on the D$ until it
//   completes. The response is routed back to the owning port, and the D$
//   enable is held low for one cycle between transactions. M has fixed
//   priority, but C is forced through after STARVE_LIMIT consecutive M grants
//   made while C was waiting. A sticky watchdog flags a D$ that never
//   completes.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   virtual_en          translation enable for pipeline accesses
//   m_req_* / m_resp_*  walker request (held until response) and response pulse
//   c_req_* / c_resp_*  pipeline request (held until response) and response pulse
//   dc_*                D$ request outputs and completion inputs
//   owner               0 = M, 1 = C; meaningful while dc_en = 1
//   err_timeout         sticky flag: a transaction stayed BUSY for TIMEOUT cycles
module dcache_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        virtual_en,
    input  logic        m_req_valid,
    input  logic [63:0] m_req_addr,
    output logic        m_resp_valid,
    output logic [63:0] m_resp_data,
    input  logic        c_req_valid,
    input  logic [63:0] c_req_addr,
    input  logic        c_req_write,
    input  logic [63:0] c_req_wdata,
    input  logic [1:0]  c_req_wlen,
    output logic        c_resp_valid,
    output logic [63:0] c_resp_rdata,
    output logic        dc_en,
    output logic [63:0] dc_addr,
    output logic        dc_write_en,
    output logic [63:0] dc_wdata,
    output logic [1:0]  dc_wlen,
    output logic        dc_virtual_mode,
    input  logic [63:0] dc_rdata,
    input  logic        dc_rvalid,
    input  logic        dc_write_done,
    output logic        owner,
    output logic        err_timeout
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TIMER_W  = $clog2(TIMEOUT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_GAP
    } state_e;

    state_e              state_q;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic                err_q;
    logic                dc_en_q;
    logic                owner_q;
    logic                write_q;
    logic [63:0]         addr_q;
    logic [63:0]         wdata_q;
    logic [1:0]          wlen_q;

    logic                grant_c;
    logic                done;

    // C wins when M is idle, or when M has been granted STARVE_LIMIT times in a
    // row while C was waiting.
    assign grant_c = c_req_valid && (!m_req_valid || (starve_q == STARVE_MAX));

    // Completion is qualified by the latched write bit so a stray rvalid cannot
    // finish a store (and vice versa).
    assign done = (state_q == ST_BUSY) && (write_q ? dc_write_done : dc_rvalid);

    always_comb begin
        starve_d = '0;
        if (c_req_valid) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
        end
        timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            dc_en_q  <= 1'b0;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wlen_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_req_valid || c_req_valid) begin
                        state_q <= ST_BUSY;
                        dc_en_q <= 1'b1;
                        owner_q <= grant_c;
                        timer_q <= '0;
                        if (grant_c) begin
                            addr_q   <= c_req_addr;
                            write_q  <= c_req_write;
                            wdata_q  <= c_req_wdata;
                            wlen_q   <= c_req_wlen;
                            starve_q <= '0;
                        end else begin
                            // Walker accesses are always plain reads.
                            addr_q   <= m_req_addr;
                            write_q  <= 1'b0;
                            wdata_q  <= '0;
                            wlen_q   <= '0;
                            starve_q <= starve_d;
                        end
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state_q <= ST_GAP;
                        dc_en_q <= 1'b0;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_d;
                        // Flag on the edge the timer reaches TIMEOUT; keep waiting.
                        if (timer_d == TIMER_MAX) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    dc_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign dc_en           = dc_en_q;
    assign dc_addr         = addr_q;
    assign dc_write_en     = write_q;
    assign dc_wdata        = wdata_q;
    assign dc_wlen         = wlen_q;
    assign dc_virtual_mode = dc_en_q && owner_q && virtual_en;
    assign owner           = owner_q;
    assign err_timeout     = err_q;

    assign m_resp_valid = done && !owner_q;
    assign m_resp_data  = m_resp_valid ? dc_rdata : '0;
    assign c_resp_valid = done && owner_q;
    assign c_resp_rdata = (c_resp_valid && !write_q) ? dc_rdata : '0;

endmodule
